// File: rtl/eth_pcs_block_lock.sv
// 64b/66b sync-header block lock FSM with RX gearbox slip control; optional header error count via ETH_PCS_LOCK_ERR_CNT_EN.
// Latency: o_slip and o_block_lock are registered one cycle after the header; o_descr_clk_en is combinational.
// Backpressure: none; i_clk_en=0 freezes all state, and o_slip is a self-clearing single-cycle pulse.
module eth_pcs_block_lock #(
    parameter int SH_CNT_MAX     = 64,
    parameter int SH_INVALID_MAX = 16,
    parameter int SLIP_HOLDOFF   = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clk_en,
    input  logic       i_hdr_valid,
    input  logic [1:0] i_hdr,
    output logic       o_slip,
    output logic       o_block_lock,
    output logic       o_descr_clk_en,
    output logic [7:0] o_hdr_err_cnt
);
    localparam int CW = $clog2(SH_CNT_MAX + 1);
    localparam int IW = $clog2(SH_INVALID_MAX + 1);
    localparam int HW = $clog2(SLIP_HOLDOFF + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(SH_CNT_MAX);
    localparam logic [IW-1:0] INV_MAX   = IW'(SH_INVALID_MAX);
    localparam logic [HW-1:0] HOLD_LAST = HW'(SLIP_HOLDOFF - 1);

    typedef enum logic [1:0] {HUNT, LOCKED, SLIP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] sh_cnt, sh_cnt_nxt, sh_cnt_inc;
    logic [IW-1:0] sh_invalid_cnt, sh_invalid_nxt, sh_invalid_inc;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          slip_nxt, lock_nxt;
    logic          hdr_stb, hdr_ok;

    assign hdr_stb        = i_clk_en & i_hdr_valid;
    assign hdr_ok         = i_hdr[1] ^ i_hdr[0];
    // Both counters are cleared before reaching their max, so the increments cannot wrap.
    assign sh_cnt_inc     = sh_cnt + 1'b1;
    assign sh_invalid_inc = sh_invalid_cnt + IW'(!hdr_ok);
    assign o_descr_clk_en = i_clk_en & o_block_lock;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state          <= HUNT;
            sh_cnt         <= '0;
            sh_invalid_cnt <= '0;
            hold_cnt       <= '0;
            o_slip         <= 1'b0;
            o_block_lock   <= 1'b0;
        end else begin
            state          <= state_nxt;
            sh_cnt         <= sh_cnt_nxt;
            sh_invalid_cnt <= sh_invalid_nxt;
            hold_cnt       <= hold_nxt;
            o_slip         <= slip_nxt;
            o_block_lock   <= lock_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        sh_cnt_nxt     = sh_cnt;
        sh_invalid_nxt = sh_invalid_cnt;
        hold_nxt       = hold_cnt;
        slip_nxt       = 1'b0;
        lock_nxt       = o_block_lock;
        case (state)
            HUNT: begin
                if (hdr_stb) begin
                    if (!hdr_ok) begin
                        state_nxt      = SLIP;
                        sh_cnt_nxt     = '0;
                        sh_invalid_nxt = '0;
                        hold_nxt       = '0;
                        slip_nxt       = 1'b1;
                    end else if (sh_cnt_inc == CNT_MAX) begin
                        state_nxt      = LOCKED;
                        sh_cnt_nxt     = '0;
                        sh_invalid_nxt = '0;
                        lock_nxt       = 1'b1;
                    end else begin
                        sh_cnt_nxt     = sh_cnt_inc;
                    end
                end
            end
            LOCKED: begin
                // Loss of lock is tested first so it wins over a window closing on the same header.
                if (hdr_stb) begin
                    if (sh_invalid_inc == INV_MAX) begin
                        state_nxt      = SLIP;
                        sh_cnt_nxt     = '0;
                        sh_invalid_nxt = '0;
                        hold_nxt       = '0;
                        slip_nxt       = 1'b1;
                        lock_nxt       = 1'b0;
                    end else if (sh_cnt_inc == CNT_MAX) begin
                        sh_cnt_nxt     = '0;
                        sh_invalid_nxt = '0;
                    end else begin
                        sh_cnt_nxt     = sh_cnt_inc;
                        sh_invalid_nxt = sh_invalid_inc;
                    end
                end
            end
            SLIP: begin
                if (i_clk_en) begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_nxt = HUNT;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt  = hold_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

`ifdef ETH_PCS_LOCK_ERR_CNT_EN
    logic err_inc;
    assign err_inc = (state == LOCKED) & hdr_stb & !hdr_ok;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_hdr_err_cnt <= '0;
        end else if (err_inc && (o_hdr_err_cnt != 8'hFF)) begin
            o_hdr_err_cnt <= o_hdr_err_cnt + 8'd1;
        end
    end
`else
    assign o_hdr_err_cnt = '0;
`endif

endmodule

// File: tb/tb_eth_pcs_block_lock.sv
// Directed bench for eth_pcs_block_lock: window-queue reference model checked every cycle, plus literal checkpoints.
module tb_eth_pcs_block_lock;
    localparam int CNT_MAX = 64;
    localparam int INV_MAX = 16;
    localparam int HOLDOFF = 4;
    localparam int M_HUNT = 0, M_LOCK = 1, M_SLIP = 2;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_clk_en = 1'b0;
    logic       i_hdr_valid = 1'b0;
    logic [1:0] i_hdr = 2'b00;
    logic       o_slip, o_block_lock, o_descr_clk_en;
    logic [7:0] o_hdr_err_cnt;

    int n_chk = 0;
    int n_fail = 0;

    eth_pcs_block_lock #(
        .SH_CNT_MAX(CNT_MAX), .SH_INVALID_MAX(INV_MAX), .SLIP_HOLDOFF(HOLDOFF)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en),
        .i_hdr_valid(i_hdr_valid), .i_hdr(i_hdr),
        .o_slip(o_slip), .o_block_lock(o_block_lock),
        .o_descr_clk_en(o_descr_clk_en), .o_hdr_err_cnt(o_hdr_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: a run length while hunting, a queue holding the current window while locked.
    int m_mode = M_HUNT;
    int m_run  = 0;
    int m_hold = 0;
    int m_slip = 0;
    int m_lock = 0;
    int m_err  = 0;
    bit m_win[$];

    function automatic int count_bad();
        int c = 0;
        foreach (m_win[k]) c += int'(m_win[k]);
        return c;
    endfunction

    initial begin
        forever begin
            @(posedge i_clk or posedge i_reset);
            if (i_reset) begin
                m_mode = M_HUNT; m_run = 0; m_hold = 0;
                m_slip = 0; m_lock = 0; m_err = 0;
                m_win.delete();
            end else begin
                bit good;
                good = (i_hdr == 2'b01) || (i_hdr == 2'b10);
                m_slip = 0;
                if (i_clk_en) begin
                    if (m_mode == M_HUNT && i_hdr_valid) begin
                        if (good) begin
                            m_run++;
                            if (m_run == CNT_MAX) begin
                                m_mode = M_LOCK; m_lock = 1; m_run = 0;
                                m_win.delete();
                            end
                        end else begin
                            m_run = 0; m_slip = 1; m_mode = M_SLIP; m_hold = HOLDOFF;
                        end
                    end else if (m_mode == M_LOCK && i_hdr_valid) begin
                        m_win.push_back(!good);
                        if (!good && m_err < 255) m_err++;
                        if (count_bad() == INV_MAX) begin
                            m_lock = 0; m_slip = 1; m_mode = M_SLIP; m_hold = HOLDOFF;
                            m_win.delete();
                        end else if (m_win.size() == CNT_MAX) begin
                            m_win.delete();
                        end
                    end else if (m_mode == M_SLIP) begin
                        m_hold--;
                        if (m_hold == 0) m_mode = M_HUNT;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_err(input int n);
`ifdef ETH_PCS_LOCK_ERR_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge i_clk);
            chk("slip", int'(o_slip), m_slip);
            chk("block_lock", int'(o_block_lock), m_lock);
            chk("descr_clk_en", int'(o_descr_clk_en), int'(i_clk_en) & m_lock);
            chk("hdr_err_cnt", int'(o_hdr_err_cnt), exp_err(m_err));
        end
    end

    task automatic cyc(input logic en, input logic vld, input logic [1:0] h);
        i_clk_en = en; i_hdr_valid = vld; i_hdr = h;
        @(posedge i_clk);
        #1;
    endtask

    task automatic good_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);
    endtask

    task automatic bad_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, (i % 2 == 0) ? 2'b11 : 2'b00);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 2'b00);
        i_reset = 1'b0;
    endtask

    initial begin
        cyc(1'b0, 1'b0, 2'b00);
        cyc(1'b0, 1'b0, 2'b00);
        chk("rst_lock", int'(o_block_lock), 0);
        chk("rst_slip", int'(o_slip), 0);
        chk("rst_err", int'(o_hdr_err_cnt), 0);
        i_reset = 1'b0;

        // Acquire lock on 64 alternating valid headers.
        good_n(63);
        chk("acq_lock_63", int'(o_block_lock), 0);
        good_n(1);
        chk("acq_lock_64", int'(o_block_lock), 1);
        chk("acq_no_slip", int'(o_slip), 0);

        // Invalid header after 63 valid in HUNT: slip, 4 ignored headers, full re-acquire.
        do_reset();
        good_n(63);
        cyc(1'b1, 1'b1, 2'b11);
        chk("hunt_slip", int'(o_slip), 1);
        chk("hunt_slip_lock", int'(o_block_lock), 0);
        good_n(1);
        chk("slip_one_cycle", int'(o_slip), 0);
        good_n(3);
        good_n(63);
        chk("reacq_lock_63", int'(o_block_lock), 0);
        good_n(1);
        chk("reacq_lock_64", int'(o_block_lock), 1);

        // 15 invalid in a window keeps lock; the 16th in the next window too.
        bad_n(15);
        good_n(49);
        chk("win15_lock", int'(o_block_lock), 1);
        chk("win15_err", int'(o_hdr_err_cnt), exp_err(15));
        bad_n(1);
        chk("win_next_lock", int'(o_block_lock), 1);
        chk("win_next_err", int'(o_hdr_err_cnt), exp_err(16));
        good_n(63);

        // 16th invalid as the 64th header of a window: loss of lock has priority.
        good_n(48);
        bad_n(15);
        chk("win16_pre_lock", int'(o_block_lock), 1);
        bad_n(1);
        chk("win16_lock", int'(o_block_lock), 0);
        chk("win16_slip", int'(o_slip), 1);
        chk("win16_err", int'(o_hdr_err_cnt), exp_err(32));
        good_n(1);
        chk("win16_slip_end", int'(o_slip), 0);

        // Clock enable toggling: only enabled strobes count; disabled invalid headers are ignored.
        do_reset();
        for (int i = 0; i < 63; i++) begin
            cyc(1'b1, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10);
            cyc(1'b0, 1'b1, 2'b11);
            chk("en_descr_off", int'(o_descr_clk_en), 0);
        end
        chk("en_lock_63", int'(o_block_lock), 0);
        cyc(1'b1, 1'b1, 2'b10);
        chk("en_lock_64", int'(o_block_lock), 1);
        chk("en_descr_on", int'(o_descr_clk_en), 1);
        cyc(1'b0, 1'b1, 2'b11);
        chk("en_descr_gate", int'(o_descr_clk_en), 0);
        chk("en_lock_hold", int'(o_block_lock), 1);

        // Reset during SLIP after 2 holdoff cycles: sequence abandoned, no late slip.
        do_reset();
        good_n(5);
        cyc(1'b1, 1'b1, 2'b00);
        chk("rs_slip", int'(o_slip), 1);
        good_n(2);
        i_reset = 1'b1;
        cyc(1'b1, 1'b1, 2'b01);
        chk("rs_lock", int'(o_block_lock), 0);
        chk("rs_slip_rst", int'(o_slip), 0);
        chk("rs_err", int'(o_hdr_err_cnt), 0);
        i_reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            good_n(1);
            chk("rs_no_slip", int'(o_slip), 0);
        end
        good_n(55);
        chk("rs_relock_63", int'(o_block_lock), 0);
        good_n(1);
        chk("rs_relock_64", int'(o_block_lock), 1);

        @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
